// File: rtl/sram_bank.sv
// Single-port SRAM bank behind a fixed-latency request/ack handshake.
// After reset an INIT sweep writes zero to every word. Each accepted request
// then takes PRECHARGE -> ACCESS -> RESP, and ack is seen in the cycle after
// RESP, so the next request can be accepted four edges after the previous one.
module sram_bank #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [WIDTH-1:0]  wmask,
    output logic [WIDTH-1:0]  rdata,
    output logic              ack,
    output logic              busy,
    output logic              init_done
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_PRE,
        S_ACC,
        S_RESP
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic              init_last;
    logic              ack_nxt;

    // Request fields captured at acceptance; later input changes are ignored
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [WIDTH-1:0]  lat_wdata;
    logic [WIDTH-1:0]  lat_wmask;
    logic              in_range;

    // The array has no reset; only the INIT sweep clears it
    logic [WIDTH-1:0]  mem [0:DEPTH-1];

    assign init_last = (int'(init_cnt) == DEPTH - 1);
    assign in_range  = (int'(lat_addr) < DEPTH);

    // State register, sweep counter, registered ack and sticky init_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            init_cnt  <= '0;
            ack       <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state <= state_nxt;
            ack   <= ack_nxt;
            if (state == S_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_last) init_done <= 1'b1;
            end
        end
    end

    // Next-state logic: req only matters in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (init_last) state_nxt = S_IDLE;
            S_IDLE:  if (req) state_nxt = S_PRE;
            S_PRE:   state_nxt = S_ACC;
            S_ACC:   state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    // Outputs: busy straight from state; ack is registered off RESP
    always_comb begin
        busy    = (state != S_IDLE);
        ack_nxt = (state == S_RESP);
    end

    // Capture the request on the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
        end else if (state == S_IDLE && req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_wmask <= wmask;
        end
    end

    // Read data only moves on a read ACCESS; out-of-range reads return zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (state == S_ACC && !lat_we) begin
            rdata <= in_range ? mem[lat_addr] : '0;
        end
    end

    // Array writes: zero sweep during INIT, masked write during a write ACCESS
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[init_cnt] <= '0;
        end else if (state == S_ACC && lat_we && in_range) begin
            mem[lat_addr] <= (mem[lat_addr] & ~lat_wmask) | (lat_wdata & lat_wmask);
        end
    end

endmodule

// File: tb/tb_sram_bank.sv
// Bench for sram_bank: a 16-word and a 12-word bank share one stimulus stream
// and are checked against an array model of the access rules.
module tb_sram_bank;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] wmask;

    logic [7:0] rd16, rd12;
    logic       ack16, ack12, busy16, busy12, done16, done12;

    int checks   = 0;
    int failures = 0;

    // Reference state: word contents and last read value per bank
    logic [7:0] m16 [16];
    logic [7:0] m12 [16];
    logic [7:0] exp16, exp12;

    sram_bank u16 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .wmask(wmask), .rdata(rd16), .ack(ack16),
        .busy(busy16), .init_done(done16)
    );

    sram_bank #(.WIDTH(8), .DEPTH(12), .ADDR_W(4)) u12 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .wmask(wmask), .rdata(rd12), .ack(ack12),
        .busy(busy12), .init_done(done12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Assert reset, check the asynchronous values, release and follow the sweep
    task automatic do_reset();
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wmask = '0;
        #1;
        chk("rst_busy16", 32'(busy16), 32'd1);
        chk("rst_busy12", 32'(busy12), 32'd1);
        chk("rst_ack16", 32'(ack16), 32'd0);
        chk("rst_ack12", 32'(ack12), 32'd0);
        chk("rst_done16", 32'(done16), 32'd0);
        chk("rst_done12", 32'(done12), 32'd0);
        chk("rst_rdata16", 32'(rd16), 32'd0);
        chk("rst_rdata12", 32'(rd12), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m16[i] = '0;
            m12[i] = '0;
        end
        exp16 = '0;
        exp12 = '0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            chk("init_busy16", 32'(busy16), 32'(e < 16));
            chk("init_done16", 32'(done16), 32'(e >= 16));
            chk("init_busy12", 32'(busy12), 32'(e < 12));
            chk("init_done12", 32'(done12), 32'(e >= 12));
        end
    endtask

    // One transaction, started #1 after an edge with both banks idle.
    // hold keeps req high (with scrambled fields) so a following call is back-to-back.
    task automatic txn(input bit w, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] m, input bit hold);
        logic [7:0] old16, old12;
        req = 1'b1; we = w; addr = a; wdata = d; wmask = m;
        @(posedge clk); #1;
        if (hold) begin
            we = ~w; addr = ~a; wdata = ~d; wmask = 8'hFF;
        end else begin
            req = 1'b0;
        end
        chk("pre_busy16", 32'(busy16), 32'd1);
        chk("pre_ack16", 32'(ack16), 32'd0);
        chk("pre_busy12", 32'(busy12), 32'd1);
        old16 = exp16;
        old12 = exp12;
        if (w) begin
            m16[a] = (m16[a] & ~m) | (d & m);
            if (a < 12) m12[a] = (m12[a] & ~m) | (d & m);
        end else begin
            exp16 = m16[a];
            exp12 = (a < 12) ? m12[a] : 8'h00;
        end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            chk("ack16", 32'(ack16), 32'(k == 3));
            chk("ack12", 32'(ack12), 32'(k == 3));
            chk("busy16", 32'(busy16), 32'(k < 3));
            if (k == 1) begin
                chk("rdata16_hold", 32'(rd16), 32'(old16));
                chk("rdata12_hold", 32'(rd12), 32'(old12));
            end
        end
        chk("rdata16", 32'(rd16), 32'(exp16));
        chk("rdata12", 32'(rd12), 32'(exp12));
    endtask

    initial begin
        bit         w, h;
        logic [3:0] a;
        logic [7:0] d, m;

        do_reset();

        // Fresh sweep reads back zero
        txn(1'b0, 4'd5, 8'h00, 8'h00, 1'b0);

        // Write then read
        txn(1'b1, 4'd3, 8'hA5, 8'hFF, 1'b0);
        txn(1'b0, 4'd3, 8'h00, 8'h00, 1'b0);

        // Masked write: 0xF0 with 0x0F under 0x3C gives 0xCC
        txn(1'b1, 4'd7, 8'hF0, 8'hFF, 1'b0);
        txn(1'b1, 4'd7, 8'h0F, 8'h3C, 1'b0);
        txn(1'b0, 4'd7, 8'h00, 8'h00, 1'b0);
        chk("masked_value", 32'(rd16), 32'h00CC);

        // Back-to-back with req held across ack
        txn(1'b1, 4'd1, 8'h11, 8'hFF, 1'b1);
        txn(1'b0, 4'd1, 8'h00, 8'h00, 1'b0);

        // Zero mask leaves the word alone
        txn(1'b1, 4'd3, 8'h5A, 8'h00, 1'b0);
        txn(1'b0, 4'd3, 8'h00, 8'h00, 1'b0);

        // Address 13 is out of range for the 12-word bank only
        txn(1'b1, 4'd13, 8'h55, 8'hFF, 1'b0);
        txn(1'b0, 4'd13, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) txn(1'b0, 4'(i), 8'h00, 8'h00, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            h = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
            txn(w, a, d, m, h);
        end

        // Reset during INIT restarts the sweep
        rst_n = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midinit_done16", 32'(done16), 32'd0);
        do_reset();

        // Reset in the PRECHARGE cycle of a write aborts it
        txn(1'b1, 4'd2, 8'h3C, 8'hFF, 1'b0);
        txn(1'b0, 4'd2, 8'h00, 8'h00, 1'b0);
        req = 1'b1; we = 1'b1; addr = 4'd2; wdata = 8'h77; wmask = 8'hFF;
        @(posedge clk); #1;
        req = 1'b0;
        chk("abort_pre_busy", 32'(busy16), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_rdata16", 32'(rd16), 32'd0);
        chk("abort_rdata12", 32'(rd12), 32'd0);
        chk("abort_busy", 32'(busy16), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("abort_noack16", 32'(ack16), 32'd0);
            chk("abort_noack12", 32'(ack12), 32'd0);
        end
        do_reset();
        txn(1'b0, 4'd2, 8'h00, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_bank.md
SRAM_BANK -- requirements
Module: sram_bank

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, >= 1.
REQ-002 Parameter DEPTH, default 16: number of words, 1 <= DEPTH <= 2**ADDR_W.
REQ-003 Parameter ADDR_W, default 4: address width in bits.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  access request, level-sampled in IDLE only.
REQ-007 we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  ADDR_W  word address; sampled with req.
REQ-009 wdata  input  WIDTH  write data; sampled with req.
REQ-010 wmask  input  WIDTH  per-bit write enable, 1 = bit written; sampled with req.
REQ-011 rdata  output  WIDTH  read data, registered.
REQ-012 ack  output  1  one-cycle completion pulse.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 init_done  output  1  high once the post-reset clear sweep has finished.

Function
REQ-015 The FSM SHALL have states INIT, IDLE, PRECHARGE, ACCESS and RESP.
REQ-016 INIT SHALL write all-zero to word 0..DEPTH-1, one word per cycle, over exactly DEPTH cycles, using an internal counter from 0.
REQ-017 After the INIT cycle for word DEPTH-1, the FSM SHALL enter IDLE and init_done SHALL go to 1 and stay 1 until the next reset.
REQ-018 req SHALL be ignored in every state except IDLE, with no queuing.
REQ-019 In IDLE with req=1, the block SHALL latch we, addr, wdata and wmask on that edge and go to PRECHARGE.
REQ-020 PRECHARGE SHALL last one cycle with no array access, then go to ACCESS.
REQ-021 ACCESS SHALL last one cycle.
- Write: mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask).
- Read: rdata <= mem[addr].
- Then go to RESP.
REQ-022 RESP SHALL drive ack=1 for exactly one cycle, then return to IDLE.
REQ-023 Latency SHALL be fixed: request accepted at edge T, ack high in the cycle after edge T+3, and the next acceptance possible at edge T+4.
REQ-024 The requester SHALL drop req in the ack cycle; if req is still high in IDLE, that is a new transaction (back-to-back allowed).
REQ-025 rdata SHALL change only in a read ACCESS cycle and SHALL hold its value through writes, IDLE and INIT.
REQ-026 wmask = 0 SHALL complete a full handshake and leave the word unchanged.
REQ-027 addr >= DEPTH SHALL still complete the full handshake.
- Write: discarded, no word modified.
- Read: rdata <= 0.
REQ-028 A read ACCESS SHALL see every write whose ACCESS completed earlier, including the immediately preceding transaction.
REQ-029 busy SHALL equal (state != IDLE), so busy is 1 throughout INIT.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock edge, force: state=INIT, INIT counter=0, rdata=0, ack=0, busy=1, init_done=0, and clear all latched request fields.
REQ-031 The memory array SHALL NOT be asynchronously reset; it is cleared only by the INIT sweep.
REQ-032 Reset asserted mid-transaction SHALL abort it.
- Any in-flight write not yet in ACCESS is lost.
- No ack is issued.
- The INIT sweep restarts from word 0 after release.
REQ-033 Reset assertion during INIT SHALL restart the sweep from word 0.

Verification
REQ-034 Reset/init (WIDTH=8, DEPTH=16, ADDR_W=4): release rst_n -> busy=1 and init_done=0 for 16 cycles, then init_done=1 and busy=0; read of addr 5 -> rdata=0x00.
REQ-035 Write then read: write addr=3, wdata=0xA5, wmask=0xFF, then read addr=3 -> ack on the 4th cycle after each acceptance; rdata=0xA5.
REQ-036 Masked write: word 7=0xF0, write wdata=0x0F, wmask=0x3C -> read returns 0xCC.
REQ-037 Back-to-back: req held high across ack with write addr 1=0x11, then read addr 1 -> second acceptance at the edge after ack; rdata=0x11; ack pulses 4 cycles apart.
REQ-038 Out of range (DEPTH=12): write addr=13 wdata=0x55, then read addr=13 -> both acked; rdata=0x00; words 0..11 unchanged.
REQ-039 Reset mid-op: assert rst_n=0 in the PRECHARGE cycle of a write of 0x77 to addr 2 -> ack never pulses; rdata=0 at once; after a fresh sweep, read addr 2 -> 0x00.
